// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the mode and FSM enums, LED pattern constants and the step-index type.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int LED_W = 8;
    typedef logic [LED_W-1:0] led_t;

    localparam led_t LED_BLANK = 8'h00;
    localparam led_t LED_FULL  = 8'hFF;

    // Steps already taken in the current pattern cycle; BOUNCE needs up to 14.
    localparam int IDX_W = 4;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/led_tick_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 while enabled and holds its count while disabled.
// o_step is combinational and high during the last count, so a step lands on the wrapping edge.
module led_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_step
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_step = i_en && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: FILL/CHASE/BLINK/BOUNCE with a one-slot mode handshake; all outputs registered.
// BOUNCE is built only with LED_SEQ_BOUNCE_EN; otherwise mode 3 is captured as CHASE.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             pause,
    input  logic             mode_req,
    input  logic [1:0]       mode_sel,
    output logic             mode_ack,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       mode_cur,
    output logic             cycle_done
);

    state_e r_state;
    mode_e  r_mode;
    mode_e  r_pend_mode;
    logic   r_pend_vld;
    led_t   r_led;
    idx_t   r_idx;
    logic   r_mode_ack;
    logic   r_cycle_done;

    logic   w_step;
    mode_e  w_sel_mode;
    led_t   w_nxt_led;
    idx_t   w_nxt_idx;
    logic   w_nxt_done;

    // Pause freezes the prescaler on the same edge it is seen, not one cycle later.
    led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .i_en   ((r_state == ST_RUN) && run_en && !pause),
        .i_clr  ((r_state == ST_IDLE) || !run_en),
        .o_step (w_step)
    );

`ifdef LED_SEQ_BOUNCE_EN
    assign w_sel_mode = mode_e'(mode_sel);
`else
    assign w_sel_mode = (mode_sel == 2'd3) ? MODE_CHASE : mode_e'(mode_sel);
`endif

    always_comb begin
        w_nxt_led  = LED_BLANK;
        w_nxt_idx  = '0;
        w_nxt_done = 1'b0;
        case (r_mode)
            MODE_FILL: begin
                if (r_idx == 4'd8) begin
                    w_nxt_done = 1'b1;
                end else begin
                    w_nxt_led = (led_t'(2) << r_idx) - led_t'(1);
                    w_nxt_idx = r_idx + 4'd1;
                end
            end
            MODE_CHASE: begin
                if (r_idx == 4'd8) begin
                    w_nxt_led  = led_t'(1);
                    w_nxt_idx  = 4'd1;
                    w_nxt_done = 1'b1;
                end else begin
                    w_nxt_led = led_t'(1) << r_idx;
                    w_nxt_idx = r_idx + 4'd1;
                end
            end
            MODE_BLINK: begin
                if (r_idx == 4'd1) begin
                    w_nxt_done = 1'b1;
                end else begin
                    w_nxt_led = LED_FULL;
                    w_nxt_idx = 4'd1;
                end
            end
`ifdef LED_SEQ_BOUNCE_EN
            MODE_BOUNCE: begin
                if (r_idx == 4'd14) begin
                    w_nxt_led  = led_t'(1);
                    w_nxt_idx  = 4'd1;
                    w_nxt_done = 1'b1;
                end else if (r_idx < 4'd8) begin
                    w_nxt_led = led_t'(1) << r_idx;
                    w_nxt_idx = r_idx + 4'd1;
                end else begin
                    w_nxt_led = led_t'(1) << (4'd14 - r_idx);
                    w_nxt_idx = r_idx + 4'd1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_FILL;
            r_pend_mode  <= MODE_FILL;
            r_pend_vld   <= 1'b0;
            r_led        <= LED_BLANK;
            r_idx        <= '0;
            r_mode_ack   <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_mode_ack   <= 1'b0;
            r_cycle_done <= 1'b0;

            // Capture only reads the registered slot, so a capture on a completing step waits a full cycle.
            if (mode_req && !r_pend_vld) begin
                r_pend_vld  <= 1'b1;
                r_pend_mode <= w_sel_mode;
                r_mode_ack  <= 1'b1;
            end

            if (!run_en) begin
                r_state <= ST_IDLE;
                r_led   <= LED_BLANK;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_RUN;
                    ST_RUN: begin
                        if (pause) begin
                            r_state <= ST_PAUSE;
                        end
                        if (w_step) begin
                            r_cycle_done <= w_nxt_done;
                            if (w_nxt_done && r_pend_vld) begin
                                r_led      <= LED_BLANK;
                                r_idx      <= '0;
                                r_mode     <= r_pend_mode;
                                r_pend_vld <= 1'b0;
                            end else begin
                                r_led <= w_nxt_led;
                                r_idx <= w_nxt_idx;
                            end
                        end
                    end
                    ST_PAUSE: if (!pause) r_state <= ST_RUN;
                    default:  r_state <= ST_IDLE;
                endcase
            end

            if (r_pend_vld && (r_state != ST_RUN)) begin
                r_mode     <= r_pend_mode;
                r_pend_vld <= 1'b0;
                if (r_state == ST_PAUSE) begin
                    r_led <= LED_BLANK;
                    r_idx <= '0;
                end
            end
        end
    end

    assign led        = r_led;
    assign mode_cur   = r_mode;
    assign mode_ack   = r_mode_ack;
    assign cycle_done = r_cycle_done;

endmodule
